// File: rtl/game_ctrl_if.sv
// game_ctrl_if: button/sensor inputs and display/score outputs of the round controller.
interface game_ctrl_if #(
    parameter int N_PLAYERS = 2,
    parameter int SCORE_W   = 6,
    parameter int TIME_W    = 6
);
    logic                           tick;
    logic                           startGame;
    logic                           pause;
    logic                           clear;
    logic [N_PLAYERS-1:0]           player_scored;
    logic [2:0]                     state;
    logic                           game_active;
    logic [TIME_W-1:0]              time_remaining;
    logic [N_PLAYERS*SCORE_W-1:0]   scores;
    logic [SCORE_W-1:0]             high_score;
    logic [1:0]                     winner;
    logic                           tie;
    logic                           new_record;
    logic                           round_done;

    modport master (
        output tick, startGame, pause, clear, player_scored,
        input  state, game_active, time_remaining, scores, high_score,
               winner, tie, new_record, round_done
    );

    modport slave (
        input  tick, startGame, pause, clear, player_scored,
        output state, game_active, time_remaining, scores, high_score,
               winner, tie, new_record, round_done
    );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: countdown, timed round with pause, saturating multi-player scores,
// winner/tie evaluation and session high score.
module game_ctrl #(
    parameter int GAME_SECONDS      = 30,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int N_PLAYERS         = 2,
    parameter int SCORE_W           = 6,
    parameter int TIME_W            = 6
) (
    input logic         clkIn,
    input logic         reset,
    game_ctrl_if.slave  g
);
    typedef enum logic [2:0] {IDLE = 3'd0, COUNTDOWN = 3'd1, RUNNING = 3'd2, PAUSED = 3'd3, DONE = 3'd4} state_t;

    localparam logic [SCORE_W-1:0] SMAX   = '1;
    localparam logic [TIME_W-1:0]  T_GAME = TIME_W'(GAME_SECONDS);
    localparam logic [TIME_W-1:0]  T_CD   = TIME_W'(COUNTDOWN_SECONDS);
    localparam logic [TIME_W-1:0]  T_ONE  = TIME_W'(1);

    state_t               st;
    logic                 start_q, pause_q, ga, tie, nr, rd;
    logic [N_PLAYERS-1:0] ps_q;
    logic [TIME_W-1:0]    tm;
    logic [SCORE_W-1:0]   sc    [N_PLAYERS];
    logic [SCORE_W-1:0]   sc_nx [N_PLAYERS];
    logic [SCORE_W-1:0]   hs, mx;
    logic [1:0]           win, win_nx;
    logic [2:0]           cnt;

    wire                 start_rise = g.startGame & ~start_q;
    wire                 pause_rise = g.pause & ~pause_q;
    wire [N_PLAYERS-1:0] ps_rise    = g.player_scored & ~ps_q;

    // Scores as they will be after this edge, so an expiring tick sees same-cycle points
    always_comb begin
        mx     = '0;
        win_nx = '0;
        cnt    = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            sc_nx[i] = (st == RUNNING && ps_rise[i] && sc[i] != SMAX) ? sc[i] + SCORE_W'(1) : sc[i];
            if (sc_nx[i] > mx) begin
                mx     = sc_nx[i];
                win_nx = 2'(i);
            end
        end
        for (int i = 0; i < N_PLAYERS; i++)
            cnt = cnt + {2'b0, sc_nx[i] == mx};
    end

    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            st      <= IDLE;
            ga      <= 1'b0;
            start_q <= 1'b1;
            pause_q <= 1'b1;
            ps_q    <= '1;
            tm      <= '0;
            hs      <= '0;
            win     <= '0;
            tie     <= 1'b0;
            nr      <= 1'b0;
            rd      <= 1'b0;
            for (int i = 0; i < N_PLAYERS; i++) sc[i] <= '0;
        end else begin
            start_q <= g.startGame;
            pause_q <= g.pause;
            ps_q    <= g.player_scored;
            rd      <= 1'b0;
            if (g.clear) begin
                st  <= IDLE;
                ga  <= 1'b0;
                tm  <= '0;
                win <= '0;
                tie <= 1'b0;
                nr  <= 1'b0;
                for (int i = 0; i < N_PLAYERS; i++) sc[i] <= '0;
            end else begin
                case (st)
                    IDLE, DONE: if (start_rise) begin
                        st  <= (COUNTDOWN_SECONDS > 0) ? COUNTDOWN : RUNNING;
                        ga  <= 1'(COUNTDOWN_SECONDS == 0);
                        tm  <= (COUNTDOWN_SECONDS > 0) ? T_CD : T_GAME;
                        win <= '0;
                        tie <= 1'b0;
                        nr  <= 1'b0;
                        for (int i = 0; i < N_PLAYERS; i++) sc[i] <= '0;
                    end
                    COUNTDOWN: if (g.tick) begin
                        if (tm == T_ONE) begin
                            st <= RUNNING;
                            ga <= 1'b1;
                            tm <= T_GAME;
                        end else tm <= tm - T_ONE;
                    end
                    RUNNING: begin
                        for (int i = 0; i < N_PLAYERS; i++) sc[i] <= sc_nx[i];
                        if (g.tick && tm == T_ONE) begin
                            st  <= DONE;
                            ga  <= 1'b0;
                            tm  <= '0;
                            rd  <= 1'b1;
                            win <= win_nx;
                            tie <= cnt > 3'd1;
                            if (mx > hs) begin
                                hs <= mx;
                                nr <= 1'b1;
                            end
                        end else begin
                            if (g.tick) tm <= tm - T_ONE;
                            if (pause_rise) begin
                                st <= PAUSED;
                                ga <= 1'b0;
                            end
                        end
                    end
                    PAUSED: if (pause_rise) begin
                        st <= RUNNING;
                        ga <= 1'b1;
                    end
                    default: begin
                        st <= IDLE;
                        ga <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_pack
        assign g.scores[i*SCORE_W +: SCORE_W] = sc[i];
    end

    assign g.state          = st;
    assign g.game_active    = ga;
    assign g.time_remaining = tm;
    assign g.high_score     = hs;
    assign g.winner         = win;
    assign g.tie            = tie;
    assign g.new_record     = nr;
    assign g.round_done     = rd;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed test-plan scenarios then random stimulus, every cycle
// checked against a round-level behavioural model.
module tb_game_ctrl;
    localparam int G  = 30;
    localparam int CD = 3;
    localparam int NP = 2;
    localparam int SW = 3;
    localparam int TW = 6;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    game_ctrl_if #(.N_PLAYERS(NP), .SCORE_W(SW), .TIME_W(TW)) bus ();

    game_ctrl #(
        .GAME_SECONDS(G), .COUNTDOWN_SECONDS(CD), .N_PLAYERS(NP), .SCORE_W(SW), .TIME_W(TW)
    ) dut (
        .clkIn(clk),
        .reset(rst_n),
        .g(bus)
    );

    typedef struct packed {
        logic [2:0]      st;
        logic [7:0]      tm;
        logic [7:0]      hs;
        logic [1:0]      win;
        logic            tie;
        logic            nr;
        logic            rd;
        logic [3:0][7:0] sc;
        logic            p_start;
        logic            p_pause;
        logic [3:0]      p_ps;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r = '0;
        r.p_start = 1'b1;
        r.p_pause = 1'b1;
        r.p_ps = '1;
        return r;
    endfunction

    // One clock of the game rules, written as plain round/score arithmetic
    function automatic mdl_t mdl_step(mdl_t o, logic tk, logic sg, logic pa, logic cl, logic [NP-1:0] ps);
        mdl_t n;
        logic rs, rp;
        int mx, cnt;
        n = o;
        rs = sg && !o.p_start;
        rp = pa && !o.p_pause;
        n.p_start = sg;
        n.p_pause = pa;
        n.p_ps = 4'(ps);
        n.rd = 1'b0;
        if (cl) begin
            n.st = 0; n.tm = 0; n.sc = '0; n.win = 0; n.tie = 0; n.nr = 0;
        end else if (o.st == 0 || o.st == 4) begin
            if (rs) begin
                n.sc = '0; n.win = 0; n.tie = 0; n.nr = 0;
                n.st = (CD > 0) ? 3'd1 : 3'd2;
                n.tm = (CD > 0) ? 8'(CD) : 8'(G);
            end
        end else if (o.st == 1) begin
            if (tk) begin
                if (o.tm == 1) begin n.st = 2; n.tm = 8'(G); end
                else n.tm = o.tm - 8'd1;
            end
        end else if (o.st == 2) begin
            for (int i = 0; i < NP; i++)
                if (ps[i] && !o.p_ps[i] && int'(o.sc[i]) < SMAX) n.sc[i] = o.sc[i] + 8'd1;
            if (tk && o.tm == 1) begin
                n.tm = 0; n.st = 4; n.rd = 1;
                mx = 0;
                for (int i = 0; i < NP; i++) if (int'(n.sc[i]) > mx) mx = int'(n.sc[i]);
                cnt = 0;
                n.win = 0;
                for (int i = NP - 1; i >= 0; i--)
                    if (int'(n.sc[i]) == mx) begin cnt++; n.win = 2'(i); end
                n.tie = cnt > 1;
                if (mx > int'(o.hs)) begin n.hs = 8'(mx); n.nr = 1; end
            end else begin
                if (tk) n.tm = o.tm - 8'd1;
                if (rp) n.st = 3;
            end
        end else if (o.st == 3) begin
            if (rp) n.st = 2;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= mdl_reset();
        else m <= mdl_step(m, bus.tick, bus.startGame, bus.pause, bus.clear, bus.player_scored);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("state", 32'(bus.state), 32'(m.st));
        chk("game_active", 32'(bus.game_active), 32'(m.st == 3'd2));
        chk("time_remaining", 32'(bus.time_remaining), 32'(m.tm));
        for (int i = 0; i < NP; i++)
            chk($sformatf("score%0d", i), 32'(bus.scores[i*SW +: SW]), 32'(m.sc[i]));
        chk("high_score", 32'(bus.high_score), 32'(m.hs));
        chk("winner", 32'(bus.winner), 32'(m.win));
        chk("tie", 32'(bus.tie), 32'(m.tie));
        chk("new_record", 32'(bus.new_record), 32'(m.nr));
        chk("round_done", 32'(bus.round_done), 32'(m.rd));
    end

    task automatic ticks(input int n);
        repeat (n) begin
            bus.tick = 1'b1; @(negedge clk);
            bus.tick = 1'b0; @(negedge clk);
        end
    endtask

    task automatic score(input logic [NP-1:0] mask, input int n);
        repeat (n) begin
            bus.player_scored = mask; @(negedge clk);
            bus.player_scored = '0;   @(negedge clk);
        end
    endtask

    task automatic start_pulse();
        bus.startGame = 1'b1; @(negedge clk);
        bus.startGame = 1'b0;
    endtask

    task automatic pause_pulse();
        bus.pause = 1'b1; @(negedge clk);
        bus.pause = 1'b0;
    endtask

    initial begin
        bus.tick = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
        bus.player_scored = '0; bus.startGame = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_start_idle", 32'(bus.state), 0);
        bus.startGame = 1'b0; @(negedge clk);
        start_pulse();
        chk("cd_state", 32'(bus.state), 1);
        chk("cd_time3", 32'(bus.time_remaining), 3);
        ticks(1); chk("cd_time2", 32'(bus.time_remaining), 2);
        ticks(1); chk("cd_time1", 32'(bus.time_remaining), 1);
        bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0;
        chk("run_state", 32'(bus.state), 2);
        chk("run_time", 32'(bus.time_remaining), 30);
        chk("run_active", 32'(bus.game_active), 1);
        @(negedge clk);
        score(2'b01, 9); chk("sat_score0", 32'(bus.scores[SW-1:0]), 7);
        score(2'b10, 2); chk("score1", 32'(bus.scores[2*SW-1:SW]), 2);
        ticks(10); chk("time20", 32'(bus.time_remaining), 20);
        pause_pulse(); chk("paused", 32'(bus.state), 3);
        @(negedge clk);
        ticks(5); score(2'b11, 2);
        chk("frozen_time", 32'(bus.time_remaining), 20);
        chk("frozen_s0", 32'(bus.scores[SW-1:0]), 7);
        chk("frozen_s1", 32'(bus.scores[2*SW-1:SW]), 2);
        pause_pulse(); chk("resumed", 32'(bus.state), 2);
        @(negedge clk);
        ticks(19); chk("time1", 32'(bus.time_remaining), 1);
        bus.tick = 1'b1; bus.player_scored = 2'b10; bus.pause = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0; bus.player_scored = '0; bus.pause = 1'b0;
        chk("done_state", 32'(bus.state), 4);
        chk("last_point", 32'(bus.scores[2*SW-1:SW]), 3);
        chk("rd_pulse", 32'(bus.round_done), 1);
        chk("winner0", 32'(bus.winner), 0);
        chk("no_tie", 32'(bus.tie), 0);
        chk("hs7", 32'(bus.high_score), 7);
        chk("record1", 32'(bus.new_record), 1);
        @(negedge clk); chk("rd_once", 32'(bus.round_done), 0);
        start_pulse(); ticks(5);
        rst_n = 1'b0; #1;
        chk("async_idle", 32'(bus.state), 0);
        chk("async_hs", 32'(bus.high_score), 0);
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        start_pulse(); @(negedge clk);
        ticks(3); score(2'b11, 4); ticks(30);
        chk("tie_state", 32'(bus.state), 4);
        chk("tie1", 32'(bus.tie), 1);
        chk("tie_winner", 32'(bus.winner), 0);
        chk("hs4", 32'(bus.high_score), 4);
        start_pulse(); @(negedge clk);
        ticks(3); score(2'b10, 3); ticks(30);
        chk("r3_hs", 32'(bus.high_score), 4);
        chk("r3_record", 32'(bus.new_record), 0);
        chk("r3_winner", 32'(bus.winner), 1);
        start_pulse(); @(negedge clk);
        ticks(3); score(2'b11, 2); score(2'b01, 3);
        pause_pulse(); chk("clr_paused", 32'(bus.state), 3);
        bus.clear = 1'b1; @(negedge clk); bus.clear = 1'b0;
        chk("clr_state", 32'(bus.state), 0);
        chk("clr_s0", 32'(bus.scores[SW-1:0]), 0);
        chk("clr_hs", 32'(bus.high_score), 4);
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 1999) != 0);
            bus.tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) bus.startGame = ~bus.startGame;
            if ($urandom_range(0, 19) == 0) bus.pause = ~bus.pause;
            bus.clear = ($urandom_range(0, 599) == 0);
            bus.player_scored = NP'($urandom);
        end
        @(negedge clk); rst_n = 1'b1; bus.clear = 1'b0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
